// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: frame-synchronous loading, hex decode or raw
// patterns, leading-zero blanking, PWM brightness and per-digit blinking.
module seg7_scan_ctrl #(
   parameter int DIGITS       = 8,
   parameter int DIV_W        = 15,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [8*DIGITS-1:0]   i_data,
   input  logic                  i_mode,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic                  i_load,
   input  logic                  i_blank_lz,
   input  logic [3:0]            i_bright,
   input  logic [DIGITS-1:0]     i_blink_mask,
   output logic [7:0]            o_seg,
   output logic [DIGITS-1:0]     o_sel,
   output logic                  o_frame,
   output logic                  o_pending
);

   localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] CNT_MAX    = '1;
   localparam logic [AW-1:0]    ADDR_LAST  = AW'(DIGITS - 1);
   localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic {
      BLINK_VISIBLE = 1'b0,
      BLINK_HIDDEN  = 1'b1
   } blinkPhase_e;

   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [8*DIGITS-1:0] stageData_q, stageData_d;
   logic                stageMode_q, stageMode_d;
   logic [DIGITS-1:0]   stageDp_q, stageDp_d;
   logic [8*DIGITS-1:0] shadowData_q, shadowData_d;
   logic                shadowMode_q, shadowMode_d;
   logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
   logic                pending_q, pending_d;
   logic [BW-1:0]       blinkCnt_q, blinkCnt_d;
   blinkPhase_e         blinkPhase_q, blinkPhase_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic                frame_q, frame_d;

   logic                tick;
   logic                boundary;
   logic [3:0]          curNib;
   logic [7:0]          curByte;
   logic                lzBlank;
   logic                allZero;
   logic                brightOn;
   logic                blinkOff;

   function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
      case (nib)
         4'h0: hexToSeg = 7'h40;
         4'h1: hexToSeg = 7'h79;
         4'h2: hexToSeg = 7'h24;
         4'h3: hexToSeg = 7'h30;
         4'h4: hexToSeg = 7'h19;
         4'h5: hexToSeg = 7'h12;
         4'h6: hexToSeg = 7'h02;
         4'h7: hexToSeg = 7'h78;
         4'h8: hexToSeg = 7'h00;
         4'h9: hexToSeg = 7'h10;
         4'hA: hexToSeg = 7'h08;
         4'hB: hexToSeg = 7'h03;
         4'hC: hexToSeg = 7'h46;
         4'hD: hexToSeg = 7'h21;
         4'hE: hexToSeg = 7'h06;
         default: hexToSeg = 7'h0E;
      endcase
   endfunction

   // Digit k is blanked when it and every more-significant nibble are zero; digit 0 never is.
   always_comb begin
      lzBlank = 1'b0;
      allZero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         allZero = allZero & (shadowData_q[4*k +: 4] == 4'h0);
         if ((AW'(k) == addr_q) && allZero) begin
            lzBlank = 1'b1;
         end
      end
      lzBlank = lzBlank & i_blank_lz & ~shadowMode_q;
   end

   always_comb begin
      tick     = (cnt_q == CNT_MAX);
      boundary = tick && (addr_q == ADDR_LAST);
      curNib   = shadowData_q[{addr_q, 2'b00} +: 4];
      curByte  = shadowData_q[{addr_q, 3'b000} +: 8];
      brightOn = (cnt_q[DIV_W-1 -: 4] <= i_bright);
      blinkOff = (blinkPhase_q == BLINK_HIDDEN) && i_blink_mask[addr_q];

      cnt_d = cnt_q + 1'b1;
      addr_d = addr_q;
      if (tick) begin
         addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      end

      stageData_d  = stageData_q;
      stageMode_d  = stageMode_q;
      stageDp_d    = stageDp_q;
      shadowData_d = shadowData_q;
      shadowMode_d = shadowMode_q;
      shadowDp_d   = shadowDp_q;
      pending_d    = pending_q;
      if (i_load) begin
         stageData_d = i_data;
         stageMode_d = i_mode;
         stageDp_d   = i_dp;
         pending_d   = 1'b1;
      end
      // A load arriving on the boundary cycle bypasses staging so it is not lost for a frame.
      if (boundary && (pending_q || i_load)) begin
         shadowData_d = i_load ? i_data : stageData_q;
         shadowMode_d = i_load ? i_mode : stageMode_q;
         shadowDp_d   = i_load ? i_dp   : stageDp_q;
         pending_d    = 1'b0;
      end

      blinkCnt_d   = blinkCnt_q;
      blinkPhase_d = blinkPhase_q;
      if (boundary) begin
         if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d   = '0;
            blinkPhase_d = (blinkPhase_q == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
         end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
         end
      end

      seg_d = 8'hFF;
      sel_d = '1;
      if (brightOn) begin
         sel_d = ~(DIGITS'(1) << addr_q);
         if (blinkOff) begin
            seg_d = 8'hFF;
         end else if (shadowMode_q) begin
            seg_d = curByte;
         end else if (lzBlank) begin
            seg_d = 8'hFF;
         end else begin
            seg_d = {~shadowDp_q[addr_q], hexToSeg(curNib)};
         end
      end
      frame_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         addr_q       <= '0;
         stageData_q  <= '0;
         stageMode_q  <= 1'b0;
         stageDp_q    <= '0;
         shadowData_q <= '0;
         shadowMode_q <= 1'b0;
         shadowDp_q   <= '0;
         pending_q    <= 1'b0;
         blinkCnt_q   <= '0;
         blinkPhase_q <= BLINK_VISIBLE;
         seg_q        <= 8'hFF;
         sel_q        <= '1;
         frame_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         stageData_q  <= stageData_d;
         stageMode_q  <= stageMode_d;
         stageDp_q    <= stageDp_d;
         shadowData_q <= shadowData_d;
         shadowMode_q <= shadowMode_d;
         shadowDp_q   <= shadowDp_d;
         pending_q    <= pending_d;
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
         frame_q      <= frame_d;
      end
   end

   assign o_seg     = seg_q;
   assign o_sel     = sel_q;
   assign o_frame   = frame_q;
   assign o_pending = pending_q;

endmodule
